// File: rtl/cdb_arbiter_pkg.sv
// Shared sizing constants and types for the CDB arbiter slice.
package cdb_arbiter_pkg;

  localparam int unsigned NumReq      = 4;
  localparam int unsigned CdbSz       = 2;
  localparam int unsigned PhysRegBits = 6;

  // One broadcast lane as seen by wakeup consumers.
  typedef struct packed {
    logic                   valid;
    logic [PhysRegBits-1:0] tag;
  } cdb_packet_t;

  // Pointer width that stays legal for a single requester.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_select.sv
// Combinational rotating selector: picks up to CDB_SZ requesters, scanning from start.
module cdb_arbiter_rr_select
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = NumReq,
  parameter int unsigned CDB_SZ  = CdbSz,
  parameter int unsigned PTR_W   = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]             req,
  input  logic [PTR_W-1:0]               start,
  output logic [NUM_REQ-1:0]             grant,
  output logic [CDB_SZ-1:0][NUM_REQ-1:0] lane_sel,
  output logic [PTR_W-1:0]               last_idx
);

  // Walk the scan order; the n-th hit lands on lane n until the lanes run out.
  always_comb begin
    int unsigned cnt;
    int unsigned tgt;
    grant    = '0;
    lane_sel = '0;
    last_idx = '0;
    cnt      = 0;
    tgt      = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      tgt = (32'(start) + off) % NUM_REQ;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if ((i == tgt) && req[i] && (cnt < CDB_SZ)) begin
          grant[i] = 1'b1;
          for (int unsigned k = 0; k < CDB_SZ; k++) begin
            if (k == cnt) lane_sel[k][i] = 1'b1;
          end
          last_idx = PTR_W'(i);
          cnt      = cnt + 1;
        end
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: round-robin grants to FUs, registered tag broadcast lanes.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ  = NumReq,
  parameter int unsigned CDB_SZ   = CdbSz,
  parameter int unsigned TAG_BITS = PhysRegBits
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             squash,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0][TAG_BITS-1:0] req_tag,
  output logic [NUM_REQ-1:0]               req_grant,
  output logic [CDB_SZ-1:0]                cdb_valid,
  output logic [CDB_SZ-1:0][TAG_BITS-1:0]  cdb_tag
);

  localparam int unsigned PtrW = ptr_width(NUM_REQ);

  logic [PtrW-1:0]                 rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0]                 last_idx;
  logic [NUM_REQ-1:0]              sel_grant;
  logic [CDB_SZ-1:0][NUM_REQ-1:0]  lane_sel;
  logic                            blocked;
  logic [CDB_SZ-1:0]               lane_valid_d;
  logic [CDB_SZ-1:0][TAG_BITS-1:0] lane_tag_d;

  cdb_arbiter_rr_select #(
    .NUM_REQ (NUM_REQ),
    .CDB_SZ  (CDB_SZ),
    .PTR_W   (PtrW)
  ) u_rr_select (
    .req      (req_valid),
    .start    (rr_ptr_q),
    .grant    (sel_grant),
    .lane_sel (lane_sel),
    .last_idx (last_idx)
  );

  // Reset and squash both withhold every grant; reset wins only in the flops.
  assign blocked = reset | squash;

  // Gate grants and advance the pointer past the last winner.
  always_comb begin
    req_grant = blocked ? '0 : sel_grant;
    rr_ptr_d  = rr_ptr_q;
    if (|req_grant) begin
      rr_ptr_d = (32'(last_idx) == NUM_REQ - 1) ? '0 : last_idx + 1'b1;
    end
  end

  // Lane muxes: one-hot select pulls the winning tag; idle lanes stay zero.
  always_comb begin
    lane_valid_d = '0;
    lane_tag_d   = '0;
    for (int unsigned k = 0; k < CDB_SZ; k++) begin
      lane_valid_d[k] = ~blocked & (|lane_sel[k]);
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (lane_sel[k][i] && !blocked) lane_tag_d[k] = lane_tag_d[k] | req_tag[i];
      end
    end
  end

  // Pointer and broadcast registers; lanes are rewritten every cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q  <= '0;
      cdb_valid <= '0;
      cdb_tag   <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      cdb_valid <= lane_valid_d;
      cdb_tag   <= lane_tag_d;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed literal pins plus randomized traffic
// checked every cycle against a queue-based scan model.
module tb_cdb_arbiter;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             squash = 1'b0;
  logic [3:0]       req_valid = 4'b1111;
  logic [3:0][5:0]  req_tag = {6'd13, 6'd12, 6'd11, 6'd10};
  logic [3:0]       req_grant;
  logic [1:0]       cdb_valid;
  logic [1:0][5:0]  cdb_tag;

  int checks = 0;
  int failures = 0;

  // Model state shared with the random driver (written only by the compare process).
  logic [3:0] m_grant = 4'b0;

  cdb_arbiter #(
    .NUM_REQ  (4),
    .CDB_SZ   (2),
    .TAG_BITS (6)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .squash    (squash),
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .req_grant (req_grant),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: list valid FUs in rotation order, hand the first two to lanes 0,1.
  int              m_ptr = 0;
  logic [1:0]      e_cv = 2'b0;
  logic [1:0][5:0] e_ct = '0;
  bit              e_known = 1'b0;

  always @(negedge clock) begin : compare
    int              order[$];
    int              n;
    logic [3:0]      g;
    logic [1:0]      nv;
    logic [1:0][5:0] nt;
    if (e_known) begin
      chk("model_lane_valid", 32'(cdb_valid), 32'(e_cv));
      chk("model_lane_tag", 32'(cdb_tag), 32'(e_ct));
    end
    order.delete();
    g  = '0;
    nv = '0;
    nt = '0;
    if (!reset && !squash) begin
      for (int off = 0; off < 4; off++) begin
        if (req_valid[(m_ptr + off) % 4]) order.push_back((m_ptr + off) % 4);
      end
      n = (order.size() < 2) ? order.size() : 2;
      for (int j = 0; j < n; j++) begin
        g[order[j]] = 1'b1;
        nv[j]       = 1'b1;
        nt[j]       = req_tag[order[j]];
      end
      if (n > 0) m_ptr = (order[n-1] + 1) % 4;
    end
    if (reset) m_ptr = 0;
    if (e_known || reset) chk("model_grant", 32'(req_grant), 32'(g));
    m_grant = g;
    e_cv    = nv;
    e_ct    = nt;
    e_known = e_known | reset;
  end

  task automatic cyc(input logic r, input logic s, input logic [3:0] v,
                     input logic [3:0][5:0] t);
    @(posedge clock);
    #1;
    reset     = r;
    squash    = s;
    req_valid = v;
    req_tag   = t;
  endtask

  task automatic expect_out(input string name, input logic [3:0] g, input logic [1:0] cv,
                            input logic [1:0][5:0] ct);
    @(negedge clock);
    #2;
    chk({name, "_grant"}, 32'(req_grant), 32'(g));
    chk({name, "_cdb_valid"}, 32'(cdb_valid), 32'(cv));
    chk({name, "_cdb_tag"}, 32'(cdb_tag), 32'(ct));
  endtask

  logic [3:0]      cur_v;
  logic [3:0][5:0] cur_t;
  localparam logic [3:0][5:0] T10 = {6'd13, 6'd12, 6'd11, 6'd10};

  initial begin
    repeat (2) @(posedge clock);
    expect_out("reset", 4'b0000, 2'b00, '0);
    cyc(1'b0, 1'b0, 4'b1111, T10);
    expect_out("rr_a", 4'b0011, 2'b00, '0);
    cyc(1'b0, 1'b0, 4'b1111, T10);
    expect_out("rr_b", 4'b1100, 2'b11, {6'd11, 6'd10});
    cyc(1'b0, 1'b0, 4'b1111, T10);
    expect_out("rr_c", 4'b0011, 2'b11, {6'd13, 6'd12});
    cyc(1'b0, 1'b0, 4'b0100, T10);
    expect_out("to_ptr3", 4'b0100, 2'b11, {6'd11, 6'd10});
    cyc(1'b0, 1'b0, 4'b1001, {6'd7, 6'd0, 6'd0, 6'd5});
    expect_out("wrap", 4'b1001, 2'b01, {6'd0, 6'd12});
    cyc(1'b0, 1'b0, 4'b0011, {6'd0, 6'd0, 6'd22, 6'd21});
    expect_out("wrap_lanes", 4'b0011, 2'b11, {6'd5, 6'd7});
    cyc(1'b0, 1'b0, 4'b1000, {6'd20, 6'd0, 6'd0, 6'd0});
    expect_out("ptr_was_1", 4'b1000, 2'b11, {6'd21, 6'd22});
    cyc(1'b0, 1'b0, 4'b0111, {6'd0, 6'd3, 6'd2, 6'd1});
    expect_out("stall", 4'b0011, 2'b01, {6'd0, 6'd20});
    cyc(1'b0, 1'b0, 4'b0100, {6'd0, 6'd3, 6'd0, 6'd0});
    expect_out("hold", 4'b0100, 2'b11, {6'd2, 6'd1});
    cyc(1'b0, 1'b1, 4'b1111, T10);
    expect_out("squash", 4'b0000, 2'b01, {6'd0, 6'd3});
    cyc(1'b0, 1'b0, 4'b1111, T10);
    expect_out("post_squash", 4'b1001, 2'b00, '0);
    cyc(1'b0, 1'b0, 4'b0110, T10);
    expect_out("after_sq", 4'b0110, 2'b11, {6'd10, 6'd13});
    cyc(1'b0, 1'b0, 4'b0000, '0);
    expect_out("idle_pulse", 4'b0000, 2'b11, {6'd12, 6'd11});
    cyc(1'b0, 1'b0, 4'b0000, '0);
    expect_out("idle", 4'b0000, 2'b00, '0);

    // Randomized traffic obeying the hold-until-granted handshake.
    cur_v = 4'b0;
    cur_t = '0;
    for (int c = 0; c < 1500; c++) begin
      @(posedge clock);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (m_grant[i]) cur_v[i] = 1'b0;
        if (!cur_v[i] && ($urandom_range(0, 2) != 0)) begin
          cur_v[i] = 1'b1;
          cur_t[i] = 6'($urandom_range(0, 63));
        end
      end
      req_valid = cur_v;
      req_tag   = cur_t;
      squash    = ($urandom_range(0, 9) == 0);
      reset     = ($urandom_range(0, 49) == 0);
    end
    @(posedge clock);
    #1;
    reset     = 1'b0;
    squash    = 1'b0;
    req_valid = '0;
    repeat (2) @(negedge clock);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
